// File: rtl/clkgen_cfg_ctrl.sv
// Clock generator run-time configuration sequencer: stop, update shadow, settle, restart.
// Phase tester capture (MEASURE state + synchronizer) is built only with CLKGEN_PHASE_CHECK_EN.
module clkgen_cfg_ctrl #(
  parameter int unsigned STOP_CYC           = 8,
  parameter int unsigned SETTLE_CYC         = 64,
  parameter int unsigned MEAS_CYC           = 256,
  parameter logic [3:0]  DIV_DEFAULT        = 4'd1,
  parameter logic [3:0]  TAP_COARSE_DEFAULT = 4'd0,
  parameter logic [3:0]  TAP_FINE_DEFAULT   = 4'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_cmd,
  input  logic [3:0]   req_ch,
  input  logic [7:0]   req_data,
  output logic         resp_valid,
  output logic [1:0]   resp_status,
  output logic [15:0]  resp_phase1,
  output logic [15:0]  resp_phase2,
  output logic         busy,
  output logic         scan_clk_start,
  output logic [3:0]   scan_tap_sel_coarse,
  output logic [3:0]   scan_tap_sel_fine,
  output logic [63:0]  div_bus,
  output logic [127:0] phase_sel_bus,
  input  logic [15:0]  phase_re1,
  input  logic [15:0]  phase_re2
);

  // state    | meaning
  // BOOT     | power-up settle wait before first oscillator start
  // IDLE     | ready for a host command
  // STOP     | oscillator held off before the shadow update
  // APPLY    | single-cycle update of the addressed field
  // SETTLE   | wait for the new setting to settle
  // START    | oscillator re-enabled
  // MEASURE  | wait, then capture synchronized phase tester results
  // DONE     | one-cycle response pulse
  typedef enum logic [2:0] {
    S_BOOT, S_IDLE, S_STOP, S_APPLY, S_SETTLE, S_START, S_MEASURE, S_DONE
  } state_t;

  localparam logic [15:0] LD_STOP   = 16'(STOP_CYC - 1);
  localparam logic [15:0] LD_SETTLE = 16'(SETTLE_CYC - 1);

  state_t         r_state;
  logic [15:0]    r_cnt;
  logic           r_boot;
  logic [1:0]     r_cmd;
  logic [3:0]     r_ch;
  logic [7:0]     r_data;
  logic           r_req_ready, r_busy, r_clk_start;
  logic [3:0]     r_coarse, r_fine;
  logic [63:0]    r_div;
  logic [127:0]   r_phase;
  logic           r_resp_valid;
  logic [1:0]     r_resp_status;
  logic [15:0]    r_resp_phase1, r_resp_phase2;
  logic           w_same;

`ifdef CLKGEN_PHASE_CHECK_EN
  localparam logic [15:0] LD_MEAS = 16'(MEAS_CYC - 1);
  logic [15:0] r_re1_m, r_re1_s, r_re2_m, r_re2_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_re1_m <= '0;
      r_re1_s <= '0;
      r_re2_m <= '0;
      r_re2_s <= '0;
    end else begin
      r_re1_m <= phase_re1;
      r_re1_s <= r_re1_m;
      r_re2_m <= phase_re2;
      r_re2_s <= r_re2_m;
    end
  end
`else
  // Inputs and parameter that only the capture path consumes.
  logic w_unused_phase;
  assign w_unused_phase = ^{phase_re1, phase_re2, 16'(MEAS_CYC)};
`endif

  always_comb begin
    w_same = 1'b0;
    case (req_cmd)
      2'd0:    w_same = (r_div[{req_ch, 2'b00} +: 4] == req_data[3:0]);
      2'd1:    w_same = (r_phase[{req_ch, 3'b000} +: 8] == req_data);
      2'd2:    w_same = ({r_coarse, r_fine} == req_data);
      default: w_same = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_BOOT;
      r_cnt         <= LD_SETTLE;
      r_boot        <= 1'b1;
      r_cmd         <= '0;
      r_ch          <= '0;
      r_data        <= '0;
      r_req_ready   <= 1'b0;
      r_busy        <= 1'b1;
      r_clk_start   <= 1'b0;
      r_coarse      <= TAP_COARSE_DEFAULT;
      r_fine        <= TAP_FINE_DEFAULT;
      r_div         <= {16{DIV_DEFAULT}};
      r_phase       <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_status <= 2'b00;
      r_resp_phase1 <= '0;
      r_resp_phase2 <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_BOOT: begin
          if (r_cnt == 16'd0) r_state <= S_START;
          else                r_cnt   <= r_cnt - 16'd1;
        end
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_cmd       <= req_cmd;
            r_ch        <= req_ch;
            r_data      <= req_data;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (req_cmd == 2'd3) begin
`ifdef CLKGEN_PHASE_CHECK_EN
              r_state <= S_MEASURE;
              r_cnt   <= LD_MEAS;
`else
              r_state       <= S_DONE;
              r_resp_valid  <= 1'b1;
              r_resp_status <= 2'b10;
`endif
            end else if (w_same) begin
              r_state       <= S_DONE;
              r_resp_valid  <= 1'b1;
              r_resp_status <= 2'b01;
            end else begin
              r_state     <= S_STOP;
              r_cnt       <= LD_STOP;
              r_clk_start <= 1'b0;
            end
          end
        end
        S_STOP: begin
          if (r_cnt == 16'd0) r_state <= S_APPLY;
          else                r_cnt   <= r_cnt - 16'd1;
        end
        S_APPLY: begin
          case (r_cmd)
            2'd0: r_div[{r_ch, 2'b00} +: 4]    <= r_data[3:0];
            2'd1: r_phase[{r_ch, 3'b000} +: 8] <= r_data;
            2'd2: begin
              r_coarse <= r_data[7:4];
              r_fine   <= r_data[3:0];
            end
            default: ;
          endcase
          r_state <= S_SETTLE;
          r_cnt   <= LD_SETTLE;
        end
        S_SETTLE: begin
          if (r_cnt == 16'd0) r_state <= S_START;
          else                r_cnt   <= r_cnt - 16'd1;
        end
        S_START: begin
          r_clk_start <= 1'b1;
          if (r_boot) begin
            r_boot      <= 1'b0;
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
`ifdef CLKGEN_PHASE_CHECK_EN
            r_state <= S_MEASURE;
            r_cnt   <= LD_MEAS;
`else
            r_state       <= S_DONE;
            r_resp_valid  <= 1'b1;
            r_resp_status <= 2'b00;
`endif
          end
        end
`ifdef CLKGEN_PHASE_CHECK_EN
        S_MEASURE: begin
          if (r_cnt == 16'd0) begin
            r_resp_phase1 <= r_re1_s;
            r_resp_phase2 <= r_re2_s;
            r_state       <= S_DONE;
            r_resp_valid  <= 1'b1;
            r_resp_status <= 2'b00;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`endif
        S_DONE: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign req_ready           = r_req_ready;
  assign busy                = r_busy;
  assign scan_clk_start      = r_clk_start;
  assign scan_tap_sel_coarse = r_coarse;
  assign scan_tap_sel_fine   = r_fine;
  assign div_bus             = r_div;
  assign phase_sel_bus       = r_phase;
  assign resp_valid          = r_resp_valid;
  assign resp_status         = r_resp_status;
  assign resp_phase1         = r_resp_phase1;
  assign resp_phase2         = r_resp_phase2;

endmodule

// File: tb/tb_clkgen_cfg_ctrl.sv
// Self-checking bench for clkgen_cfg_ctrl: command table, scoreboard of responses,
// boot, back-to-back and mid-sequence reset sequences.
module tb_clkgen_cfg_ctrl;

`ifdef CLKGEN_PHASE_CHECK_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif
  localparam int STOP     = 8;
  localparam int SETTLE   = 64;
  localparam int MEAS     = 256;
  localparam int WR_LAT   = STOP + SETTLE + 3 + (FEAT ? MEAS : 0);
  localparam int CMD3_LAT = FEAT ? MEAS + 1 : 1;
  localparam logic [1:0] CMD3_ST = FEAT ? 2'b00 : 2'b10;
  localparam int NVEC     = 11;

  logic clk, rst;
  logic req_valid, req_ready;
  logic [1:0] req_cmd;
  logic [3:0] req_ch;
  logic [7:0] req_data;
  logic resp_valid;
  logic [1:0] resp_status;
  logic [15:0] resp_phase1, resp_phase2;
  logic busy, scan_clk_start;
  logic [3:0] scan_tap_sel_coarse, scan_tap_sel_fine;
  logic [63:0] div_bus;
  logic [127:0] phase_sel_bus;
  logic [15:0] phase_re1, phase_re2;

  clkgen_cfg_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_ch(req_ch), .req_data(req_data),
    .resp_valid(resp_valid), .resp_status(resp_status),
    .resp_phase1(resp_phase1), .resp_phase2(resp_phase2),
    .busy(busy), .scan_clk_start(scan_clk_start),
    .scan_tap_sel_coarse(scan_tap_sel_coarse), .scan_tap_sel_fine(scan_tap_sel_fine),
    .div_bus(div_bus), .phase_sel_bus(phase_sel_bus),
    .phase_re1(phase_re1), .phase_re2(phase_re2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [3:0]  ch;
    logic [7:0]  data;
    logic [15:0] p1;
    logic [15:0] p2;
    logic [1:0]  st;
    int          lat;
  } vec_t;

  typedef struct {
    logic [1:0]  st;
    int          lat;
    logic [15:0] p1;
    logic [15:0] p2;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_chk = 0, n_fail = 0, n_resp = 0;
  int   cyc = 0, last_acc = 0, prev_acc = 0;

  logic [3:0]  m_div [16];
  logic [7:0]  m_phase [16];
  logic [3:0]  m_coarse, m_fine;
  logic [15:0] m_p1, m_p2;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] m_div_bus();
    logic [63:0] r;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = m_div[n];
    return r;
  endfunction

  function automatic logic [127:0] m_phase_bus();
    logic [127:0] r;
    for (int n = 0; n < 16; n++) r[8*n +: 8] = m_phase[n];
    return r;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 16; n++) begin
      m_div[n]   = 4'd1;
      m_phase[n] = 8'd0;
    end
    m_coarse = 4'd0;
    m_fine   = 4'd0;
    m_p1     = 16'd0;
    m_p2     = 16'd0;
  endtask

  task automatic chk_buses(input string tag);
    chk({tag, " div_bus"}, div_bus, m_div_bus());
    chk({tag, " phase_sel_bus"}, phase_sel_bus, m_phase_bus());
    chk({tag, " taps"}, {scan_tap_sel_coarse, scan_tap_sel_fine}, {m_coarse, m_fine});
  endtask

  // accept log: cycle index of every accepted command
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && req_valid === 1'b1 && req_ready === 1'b1) begin
      acc_q.push_back(cyc);
      prev_acc <= last_acc;
      last_acc <= cyc;
    end
  end

  // response scoreboard
  always @(negedge clk) begin
    if (!rst && resp_valid === 1'b1) begin
      exp_t e;
      int   a;
      n_resp++;
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        chk("unexpected resp_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("resp_status", resp_status, e.st);
        chk("resp latency", cyc - a, e.lat);
        chk("resp_phase1", resp_phase1, e.p1);
        chk("resp_phase2", resp_phase2, e.p2);
      end
    end
  end

  task automatic issue(input logic [1:0] cmd, input logic [3:0] ch, input logic [7:0] data,
                       input logic [15:0] p1, input logic [15:0] p2,
                       input logic [1:0] st, input int lat);
    exp_t e;
    int   k;
    @(negedge clk);
    req_cmd   = cmd;
    req_ch    = ch;
    req_data  = data;
    phase_re1 = p1;
    phase_re2 = p2;
    req_valid = 1'b1;
    if (FEAT && st == 2'b00) begin
      m_p1 = p1;
      m_p2 = p2;
    end
    e = '{st, lat, m_p1, m_p2};
    exp_q.push_back(e);
    if (st == 2'b00) begin
      case (cmd)
        2'd0: m_div[ch] = data[3:0];
        2'd1: m_phase[ch] = data;
        2'd2: begin
          m_coarse = data[7:4];
          m_fine   = data[3:0];
        end
        default: ;
      endcase
    end
    k = 0;
    while (req_ready !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (req_ready !== 1'b1) chk("accept timeout", 0, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_cmd   = 2'($urandom);
    req_ch    = 4'($urandom);
    req_data  = 8'($urandom);
  endtask

  task automatic wait_done(output int low_cnt, output int upd_at);
    logic [199:0] snap;
    bit done;
    snap = {div_bus, phase_sel_bus, scan_tap_sel_coarse, scan_tap_sel_fine};
    low_cnt = 0;
    upd_at  = -1;
    done    = 1'b0;
    for (int k = 1; k <= 2000 && !done; k++) begin
      @(negedge clk);
      if (scan_clk_start !== 1'b1) low_cnt++;
      if (upd_at < 0 && {div_bus, phase_sel_bus, scan_tap_sel_coarse, scan_tap_sel_fine} !== snap)
        upd_at = k;
      if (exp_q.size() == 0 && req_ready === 1'b1) done = 1'b1;
    end
    if (!done) chk("response timeout", 0, 1);
  endtask

  task automatic reset_boot(input string tag);
    int rdy_at, clk_at, n0;
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    exp_q.delete();
    acc_q.delete();
    model_reset();
    @(negedge clk);
    chk({tag, " rst scan_clk_start"}, scan_clk_start, 1'b0);
    chk({tag, " rst req_ready/busy"}, {req_ready, busy}, 2'b01);
    chk({tag, " rst resp"}, {resp_valid, resp_status, resp_phase1, resp_phase2}, 35'd0);
    chk_buses({tag, " rst"});
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    n0     = n_resp;
    rdy_at = -1;
    clk_at = -1;
    for (int k = 1; k <= 300 && rdy_at < 0; k++) begin
      @(negedge clk);
      if (scan_clk_start === 1'b1 && clk_at < 0) clk_at = k;
      if (req_ready === 1'b1) rdy_at = k;
    end
    chk({tag, " boot req_ready rise"}, rdy_at, SETTLE + 1);
    chk({tag, " boot scan_clk_start rise"}, clk_at, SETTLE + 1);
    chk({tag, " boot no resp"}, n_resp, n0);
    chk_buses({tag, " boot"});
  endtask

  vec_t tbl [NVEC];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lowc, upd, n0;
    bit  chg;
    rst = 1'b1;
    req_valid = 1'b0;
    req_cmd = '0;
    req_ch = '0;
    req_data = '0;
    phase_re1 = '0;
    phase_re2 = '0;
    model_reset();

    tbl[0]  = '{2'd0, 4'd5,  8'h03, 16'h0001, 16'h0002, 2'b00, WR_LAT};
    tbl[1]  = '{2'd0, 4'd5,  8'h03, 16'h0001, 16'h0002, 2'b01, 1};
    tbl[2]  = '{2'd2, 4'd0,  8'hA6, 16'h0303, 16'h0404, 2'b00, WR_LAT};
    tbl[3]  = '{2'd2, 4'd9,  8'hA6, 16'h0505, 16'h0606, 2'b01, 1};
    tbl[4]  = '{2'd1, 4'd15, 8'h5A, 16'h0707, 16'h0808, 2'b00, WR_LAT};
    tbl[5]  = '{2'd1, 4'd0,  8'h00, 16'h0909, 16'h0A0A, 2'b01, 1};
    tbl[6]  = '{2'd0, 4'd0,  8'hF1, 16'h0B0B, 16'h0C0C, 2'b01, 1};
    tbl[7]  = '{2'd0, 4'd15, 8'h0F, 16'h0D0D, 16'h0E0E, 2'b00, WR_LAT};
    tbl[8]  = '{2'd3, 4'd0,  8'h00, 16'h00F0, 16'hABCD, CMD3_ST, CMD3_LAT};
    tbl[9]  = '{2'd1, 4'd7,  8'hC3, 16'h1357, 16'h2468, 2'b00, WR_LAT};
    tbl[10] = '{2'd2, 4'd3,  8'hA6, 16'hFFFF, 16'hEEEE, 2'b01, 1};

    reset_boot("boot");
    chk("boot div_bus literal", div_bus, 64'h1111_1111_1111_1111);

    for (int i = 0; i < NVEC; i++) begin
      issue(tbl[i].cmd, tbl[i].ch, tbl[i].data, tbl[i].p1, tbl[i].p2, tbl[i].st, tbl[i].lat);
      wait_done(lowc, upd);
      chg = (tbl[i].st == 2'b00 && tbl[i].cmd != 2'd3);
      chk($sformatf("vec%0d clk_stop_cycles", i), lowc, chg ? STOP + SETTLE + 2 : 0);
      chk($sformatf("vec%0d update_cycle", i), upd, chg ? STOP + 2 : -1);
      chk_buses($sformatf("vec%0d", i));
    end

    // second request held while the first write is still in flight
    issue(2'd0, 4'd3, 8'h07, 16'h1111, 16'h2222, 2'b00, WR_LAT);
    issue(2'd1, 4'd3, 8'h44, 16'h1111, 16'h2222, 2'b00, WR_LAT);
    wait_done(lowc, upd);
    chk("b2b accept spacing", last_acc - prev_acc, WR_LAT + 1);
    chk_buses("b2b");

    // reset while the write sits in SETTLE: drop it and re-boot
    issue(2'd0, 4'd2, 8'h09, 16'h3333, 16'h4444, 2'b00, WR_LAT);
    repeat (30) @(negedge clk);
    chk("midrst in settle clk off", scan_clk_start, 1'b0);
    reset_boot("midrst");
    n0 = n_resp;
    repeat (WR_LAT + 5) @(negedge clk);
    chk("midrst dropped cmd no resp", n_resp, n0);

    issue(2'd0, 4'd2, 8'h09, 16'h3333, 16'h4444, 2'b00, WR_LAT);
    wait_done(lowc, upd);
    chk("post-reboot clk_stop_cycles", lowc, STOP + SETTLE + 2);
    chk_buses("post-reboot");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
